seq_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor. It is the sequential successor to the team's 64-bit combinational `adder`. Each cycle it processes one CHUNK-bit slice of a WIDTH-bit operand pair, rippling the carry through a register. This trades latency for a short critical path. It sits in the ALU datapath behind a valid/ready handshake and reports the sum, the raw carry-out and signed overflow.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/chunk_adder.sv | 18 +
 rtl/seq_addsub.sv | 133 +++++++++++++
 tb/tb_seq_addsub.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, add/sub op encoding and
// signed saturation constants for any operand width up to MAX_WIDTH.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  localparam int MAX_WIDTH = 1024;

  // Saturation limits are built wide and sliced to the operand width by the user.
  function automatic logic [MAX_WIDTH-1:0] signed_max(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] signed_min(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i == width - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice with carry-in and carry-out; the
// sequential adder reuses one of these for every chunk of the operands.
module chunk_adder #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] total;

  assign total       = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign {cout, sum} = total;

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per cycle
// behind valid/ready handshakes. Optional saturation: SEQ_ADDSUB_SAT_EN.
module seq_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef SEQ_ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N   = WIDTH / CHUNK;
  localparam int KW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("seq_addsub: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

`ifdef SEQ_ADDSUB_SAT_EN
  localparam logic [MAX_WIDTH-1:0] SAT_MAX_FULL = signed_max(WIDTH);
  localparam logic [MAX_WIDTH-1:0] SAT_MIN_FULL = signed_min(WIDTH);
  localparam logic [WIDTH-1:0]     SAT_MAX      = SAT_MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     SAT_MIN      = SAT_MIN_FULL[WIDTH-1:0];
  logic sat_reg;
`endif

  state_t            state, state_next;
  logic [WIDTH-1:0]  a_reg, b_reg, sum_reg;
  logic [WIDTH-1:0]  b_eff;
  logic              carry_reg, co_reg, ovf_reg;
  logic [KW-1:0]     k;
  logic [CHUNK-1:0]  a_chunk, b_chunk, c_sum;
  logic              c_cout;
  logic              last_chunk, ovf_next;

  assign b_eff      = (op_t'(sub) == OP_SUB) ? ~b : b;
  assign a_chunk    = a_reg[int'(k) * CHUNK +: CHUNK];
  assign b_chunk    = b_reg[int'(k) * CHUNK +: CHUNK];
  assign last_chunk = (k == K_LAST);
  // The top chunk's sum bit is the result MSB on the final CALC edge.
  assign ovf_next   = (a_reg[MSB] == b_reg[MSB]) && (c_sum[CHUNK-1] != a_reg[MSB]);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_reg),
    .sum  (c_sum),
    .cout (c_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = CALC;
      CALC:    if (last_chunk) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Operand capture at accept, then one chunk per edge rippling through carry_reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      co_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
      k         <= '0;
`ifdef SEQ_ADDSUB_SAT_EN
      sat_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b_eff;
            carry_reg <= sub;
            k         <= '0;
`ifdef SEQ_ADDSUB_SAT_EN
            sat_reg   <= sat;
`endif
          end
        end
        CALC: begin
          sum_reg[int'(k) * CHUNK +: CHUNK] <= c_sum;
          carry_reg <= c_cout;
          k         <= k + 1'b1;
          if (last_chunk) begin
            co_reg  <= c_cout;
            ovf_reg <= ovf_next;
`ifdef SEQ_ADDSUB_SAT_EN
            if (sat_reg && ovf_next) sum_reg <= a_reg[MSB] ? SAT_MIN : SAT_MAX;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_reg;
  assign carry_out = co_reg;
  assign overflow  = ovf_reg;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed self-checking bench for seq_addsub at WIDTH=64, CHUNK=16,
// followed by a strided small-operand sweep against a reference model.
module tb_seq_addsub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        sub;
  logic        sat;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        carry_out;
  logic        overflow;

  int          vectorCount;
  int          missCount;
  logic [63:0] resSum;
  logic        resCo;
  logic        resOvf;
  int          resLat;

  seq_addsub #(.WIDTH(64), .CHUNK(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
`ifdef SEQ_ADDSUB_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accept one operation and wait (bounded) until the result is presented.
  task automatic applyStimulus(input logic [63:0] av, input logic [63:0] bv, input logic s);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("in_ready_before_accept", in_ready, 1);
    a        = av;
    b        = bv;
    sub      = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    resLat   = 0;
    while (!out_valid && resLat < 20) begin
      @(posedge clk);
      #1;
      resLat++;
    end
    checkOutput("out_valid_reached", out_valid, 1);
    resSum = sum;
    resCo  = carry_out;
    resOvf = overflow;
  endtask

  task automatic releaseOutput();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [63:0] av, input logic [63:0] bv,
                          input logic s, input logic [63:0] expSum, input logic expCo,
                          input logic expOvf);
    applyStimulus(av, bv, s);
    checkOutput({tag, "_latency"}, 64'(resLat), 64'd4);
    checkOutput({tag, "_sum"}, resSum, expSum);
    checkOutput({tag, "_carry"}, 64'(resCo), 64'(expCo));
    checkOutput({tag, "_ovf"}, 64'(resOvf), 64'(expOvf));
    releaseOutput();
  endtask

  function automatic void refModel(input logic [63:0] av, input logic [63:0] bv, input logic s,
                                   output logic [63:0] r, output logic c, output logic o);
    logic [64:0] wide;
    if (s) begin
      r = av - bv;
      c = (av >= bv);
      o = (av[63] != bv[63]) && (r[63] != av[63]);
    end else begin
      wide = {1'b0, av} + {1'b0, bv};
      r    = wide[63:0];
      c    = wide[64];
      o    = (av[63] == bv[63]) && (r[63] != av[63]);
    end
  endfunction

  initial begin
    logic [63:0] holdSum;
    logic [63:0] mSum;
    logic        mCo;
    logic        mOvf;

    vectorCount = 0;
    missCount   = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = '0;
    b           = '0;
    sub         = 1'b0;
    sat         = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_sum", sum, 64'h0);
    checkOutput("reset_carry", carry_out, 0);
    checkOutput("reset_ovf", overflow, 0);
    rst_n = 1'b1;

    directed("basic_add", 64'd5, 64'd3, 1'b0, 64'd8, 1'b0, 1'b0);
    directed("unsigned_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0, 1'b1, 1'b0);
    directed("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
    directed("sub_borrow", 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    directed("min_minus_one", 64'h8000_0000_0000_0000, 64'd1, 1'b1,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    directed("chunk_ripple", 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0,
             64'h0001_0000_0000_0000, 1'b0, 1'b0);
`ifdef SEQ_ADDSUB_SAT_EN
    sat = 1'b1;
    directed("sat_max", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    directed("sat_min", 64'h8000_0000_0000_0000, 64'd1, 1'b1,
             64'h8000_0000_0000_0000, 1'b1, 1'b1);
    sat = 1'b0;
`endif

    // Backpressure: result must hold and no new accept while out_ready is low.
    applyStimulus(64'h1111_2222_3333_4444, 64'h2222_3333_4444_5555, 1'b0);
    holdSum = 64'h3333_5555_7777_9999;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_sum", sum, holdSum);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_valid", out_valid, 1);
    end
    releaseOutput();
    checkOutput("bp_in_ready_after", in_ready, 1);
    checkOutput("bp_out_valid_after", out_valid, 0);

    // In DONE with both in_valid and out_ready: only the output handshake happens.
    applyStimulus(64'd100, 64'd1, 1'b0);
    checkOutput("both_sum", resSum, 64'd101);
    @(negedge clk);
    a         = 64'd7;
    b         = 64'd7;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("both_out_valid", out_valid, 0);
    checkOutput("both_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    checkOutput("both_not_accepted", in_ready, 1);

    // Leave carry_out and overflow at 1 so the reset below is observable.
    directed("neg_neg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
             64'h0, 1'b1, 1'b1);

    @(negedge clk);
    a        = 64'h0123_4567_89AB_CDEF;
    b        = 64'd1;
    sub      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_sum", sum, 64'h0);
    checkOutput("midrst_carry", carry_out, 0);
    checkOutput("midrst_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    checkOutput("midrst_hold_out_valid", out_valid, 0);
    rst_n = 1'b1;
    directed("after_reset", 64'd10, 64'd20, 1'b0, 64'd30, 1'b0, 1'b0);

    for (int i = 0; i < 350; i += 7) begin
      for (int j = 0; j < 350; j += 7) begin
        for (int s = 0; s < 2; s++) begin
          refModel(64'(i), 64'(j), s[0], mSum, mCo, mOvf);
          applyStimulus(64'(i), 64'(j), s[0]);
          checkOutput("sweep_sum", resSum, mSum);
          checkOutput("sweep_carry", 64'(resCo), 64'(mCo));
          checkOutput("sweep_ovf", 64'(resOvf), 64'(mOvf));
          releaseOutput();
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
